// File: rtl/fp32_dot_accum_if.sv
// -----------------------------------------------------------------------------
// fp32_dot_accum_if
// Handshake bundle between the FP32 product stream, the accumulator, and the
// consumer of finished dot-product sums.
//   in_valid / in_ready / in_data[31:0] / in_last : product input handshake
//   out_valid / out_ready / out_sum[31:0] / out_count[COUNT_W-1:0] : result
// Modports:
//   master : the environment (drives products, accepts sums)
//   slave  : the accumulator
// -----------------------------------------------------------------------------
interface fp32_dot_accum_if #(
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_sum;
    logic [COUNT_W-1:0] out_count;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_last,
        input  out_valid,
        output out_ready,
        input  out_sum,
        input  out_count
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_last,
        output out_valid,
        input  out_ready,
        output out_sum,
        output out_count
    );
endinterface

// File: rtl/fp32_dot_accum.sv
// -----------------------------------------------------------------------------
// fp32_dot_accum
// Streaming FP32 accumulator for the dot-product datapath. Each accepted
// product is added to a running sum through an ALIGN -> ADD -> NORM sequence
// (one cycle each). The term flagged in_last finishes the dot product: the
// sum and term count are then presented on a held output handshake.
// Arithmetic: truncation only, quiet-NaN canonicalised to 0x7FC00000,
// denormal inputs use exponent 1 with implicit bit 0, tiny results flush to
// signed zero.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fp32_dot_accum_if.slave (product input + sum output handshakes)
//
// Configuration macro:
//   FP32_ACC_SAT_EN : when defined, finite overflow saturates to signed max
//                     finite instead of producing signed infinity.
// -----------------------------------------------------------------------------
module fp32_dot_accum #(
    parameter int COUNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp32_dot_accum_if.slave       bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t               state_q,    state_d;
    logic [31:0]          acc_q,      acc_d;
    logic [COUNT_W-1:0]   count_q,    count_d;
    logic [31:0]          opnd_q,     opnd_d;
    logic                 last_q,     last_d;
    logic                 big_sign_q, big_sign_d;
    logic [7:0]           big_exp_q,  big_exp_d;
    logic [23:0]          big_man_q,  big_man_d;
    logic [23:0]          sml_man_q,  sml_man_d;
    logic                 sub_q,      sub_d;
    logic [24:0]          sum_q,      sum_d;

    // -------------------------------------------------------------------------
    // Alignment datapath (used in ALIGN)
    // -------------------------------------------------------------------------
    logic [7:0]  acc_eff_exp, opn_eff_exp;
    logic [23:0] acc_man, opn_man;
    logic        acc_is_big;
    logic [7:0]  exp_diff;
    logic [23:0] sml_unshifted;
    logic [23:0] sml_shifted;

    always_comb begin
        acc_eff_exp = (acc_q[30:23] == 8'd0)  ? 8'd1 : acc_q[30:23];
        opn_eff_exp = (opnd_q[30:23] == 8'd0) ? 8'd1 : opnd_q[30:23];
        acc_man     = {(acc_q[30:23] != 8'd0),  acc_q[22:0]};
        opn_man     = {(opnd_q[30:23] != 8'd0), opnd_q[22:0]};
        // Exponent/mantissa field order makes the raw bit pattern a
        // magnitude order, denormals included.
        acc_is_big    = (acc_q[30:0] >= opnd_q[30:0]);
        exp_diff      = acc_is_big ? (acc_eff_exp - opn_eff_exp)
                                   : (opn_eff_exp - acc_eff_exp);
        sml_unshifted = acc_is_big ? opn_man : acc_man;
        sml_shifted   = (exp_diff >= 8'd25) ? 24'd0 : (sml_unshifted >> exp_diff);
    end

    // -------------------------------------------------------------------------
    // Normalisation and special-value resolution (used in NORM)
    // -------------------------------------------------------------------------
    logic [4:0]  lz;
    logic [9:0]  norm_exp;      // two's complement, bit 9 set means negative
    logic [23:0] norm_man;
    logic [31:0] norm_result;
    logic        acc_nan, opn_nan, acc_inf, opn_inf;

    always_comb begin
        // Highest set bit wins because later iterations overwrite earlier ones.
        lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (sum_q[i]) begin
                lz = 5'(23 - i);
            end
        end

        if (sum_q[24]) begin
            norm_man = sum_q[24:1];
            norm_exp = {2'b00, big_exp_q} + 10'd1;
        end else begin
            norm_man = sum_q[23:0] << lz;
            norm_exp = {2'b00, big_exp_q} - {5'd0, lz};
        end

        acc_nan = (acc_q[30:23] == 8'hFF)  && (acc_q[22:0] != 23'd0);
        opn_nan = (opnd_q[30:23] == 8'hFF) && (opnd_q[22:0] != 23'd0);
        acc_inf = (acc_q[30:23] == 8'hFF)  && (acc_q[22:0] == 23'd0);
        opn_inf = (opnd_q[30:23] == 8'hFF) && (opnd_q[22:0] == 23'd0);

        if (acc_nan || opn_nan) begin
            // A NaN accumulator keeps producing NaN until the sum is consumed.
            norm_result = QNAN;
        end else if (acc_inf && opn_inf && (acc_q[31] != opnd_q[31])) begin
            norm_result = QNAN;
        end else if (acc_inf) begin
            norm_result = acc_q;
        end else if (opn_inf) begin
            norm_result = opnd_q;
        end else if (sum_q == 25'd0) begin
            norm_result = 32'h0000_0000;
        end else if (norm_exp[9] || (norm_exp == 10'd0)) begin
            norm_result = {big_sign_q, 31'd0};
        end else if (norm_exp >= 10'd255) begin
`ifdef FP32_ACC_SAT_EN
            norm_result = {big_sign_q, 31'h7F7F_FFFF};
`else
            norm_result = {big_sign_q, 8'hFF, 23'd0};
`endif
        end else begin
            norm_result = {big_sign_q, norm_exp[7:0], norm_man[22:0]};
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / datapath register update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        opnd_d     = opnd_q;
        last_d     = last_q;
        big_sign_d = big_sign_q;
        big_exp_d  = big_exp_q;
        big_man_d  = big_man_q;
        sml_man_d  = sml_man_q;
        sub_d      = sub_q;
        sum_d      = sum_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    opnd_d  = bus.in_data;
                    last_d  = bus.in_last;
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                big_sign_d = acc_is_big ? acc_q[31]   : opnd_q[31];
                big_exp_d  = acc_is_big ? acc_eff_exp : opn_eff_exp;
                big_man_d  = acc_is_big ? acc_man     : opn_man;
                sml_man_d  = sml_shifted;
                sub_d      = acc_q[31] ^ opnd_q[31];
                state_d    = ST_ADD;
            end
            ST_ADD: begin
                sum_d   = sub_q ? ({1'b0, big_man_q} - {1'b0, sml_man_q})
                                : ({1'b0, big_man_q} + {1'b0, sml_man_q});
                state_d = ST_NORM;
            end
            ST_NORM: begin
                acc_d   = norm_result;
                count_d = (count_q == {COUNT_W{1'b1}}) ? count_q
                        : count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                state_d = last_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    acc_d   = 32'h0000_0000;
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= 32'h0000_0000;
            count_q    <= '0;
            opnd_q     <= 32'h0000_0000;
            last_q     <= 1'b0;
            big_sign_q <= 1'b0;
            big_exp_q  <= 8'd0;
            big_man_q  <= 24'd0;
            sml_man_q  <= 24'd0;
            sub_q      <= 1'b0;
            sum_q      <= 25'd0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            opnd_q     <= opnd_d;
            last_q     <= last_d;
            big_sign_q <= big_sign_d;
            big_exp_q  <= big_exp_d;
            big_man_q  <= big_man_d;
            sml_man_q  <= sml_man_d;
            sub_q      <= sub_d;
            sum_q      <= sum_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_sum   = acc_q;
    assign bus.out_count = count_q;

endmodule

// File: tb/tb_fp32_dot_accum.sv
// -----------------------------------------------------------------------------
// tb_fp32_dot_accum
// Self-checking bench for fp32_dot_accum: directed cases plus randomised dot
// products compared against a value-level reference model. A narrow counter
// width is used so counter saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_fp32_dot_accum;

    localparam int CW = 4;

    logic clk;
    logic rst_n;

    fp32_dot_accum_if #(.COUNT_W(CW)) bus ();

    fp32_dot_accum #(.COUNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int n_txn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: value-level FP32 add with truncating alignment
    // ---------------------------------------------------------------------
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        bit    a_nan, b_nan, a_inf, b_inf;
        int    ae, be, bige, diff, e;
        longint am, bm, bigm, smlm, m;
        bit    bigs, a_big;
        logic [31:0] r;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (a_nan || b_nan) return 32'h7FC00000;
        if (a_inf && b_inf && (a[31] != b[31])) return 32'h7FC00000;
        if (a_inf) return a;
        if (b_inf) return b;
        ae = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        be = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        am = longint'(a[22:0]) + ((a[30:23] == 0) ? 0 : 64'd8388608);
        bm = longint'(b[22:0]) + ((b[30:23] == 0) ? 0 : 64'd8388608);
        a_big = (ae > be) || ((ae == be) && (am >= bm));
        bige = a_big ? ae : be;
        bigm = a_big ? am : bm;
        bigs = a_big ? a[31] : b[31];
        smlm = a_big ? bm : am;
        diff = a_big ? (ae - be) : (be - ae);
        smlm = (diff >= 25) ? 0 : (smlm / (64'd1 << diff));
        m = (a[31] == b[31]) ? (bigm + smlm) : (bigm - smlm);
        if (m == 0) return 32'h00000000;
        e = bige;
        if (m >= 64'd16777216) begin
            m = m / 2;
            e = e + 1;
        end
        while (m < 64'd8388608) begin
            m = m * 2;
            e = e - 1;
        end
        if (e < 1) return {bigs, 31'd0};
        if (e >= 255) begin
`ifdef FP32_ACC_SAT_EN
            return {bigs, 31'h7F7FFFFF};
`else
            return {bigs, 8'hFF, 23'd0};
`endif
        end
        r = {bigs, e[7:0], m[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] ref_dot(input logic [31:0] terms[$]);
        logic [31:0] acc;
        acc = 32'h0;
        foreach (terms[i]) acc = ref_add(acc, terms[i]);
        return acc;
    endfunction

    function automatic logic [31:0] ref_cnt(input int n);
        int lim;
        lim = (1 << CW) - 1;
        return (n > lim) ? lim : n;
    endfunction

    function automatic logic [31:0] rand_term();
        int sel;
        logic [31:0] v;
        sel = $urandom_range(0, 19);
        v = $urandom;
        case (sel)
            0:       v = {v[31], 8'hFF, (v[22:0] == 0) ? 23'd1 : v[22:0]};
            1:       v = {v[31], 8'hFF, 23'd0};
            2:       v = {v[31], 31'd0};
            3:       v = {v[31], 8'h00, v[22:0]};
            4:       v = {v[31], 8'(250 + $urandom_range(0, 4)), v[22:0]};
            5:       v = {v[31], 8'd1, v[22:0]};
            default: v = {v[31], 8'(120 + $urandom_range(0, 15)), v[22:0]};
        endcase
        return v;
    endfunction

    // ---------------------------------------------------------------------
    // Bus tasks (all driving happens 1 time unit after a rising edge)
    // ---------------------------------------------------------------------
    task automatic send_term(input logic [31:0] data, input logic last);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.in_last  = 1'($urandom);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic get_result(input string tag, input logic [31:0] exp_sum, input logic [31:0] exp_cnt);
        wait_out_valid();
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
        check({tag, "_sum"}, bus.out_sum, exp_sum);
        check({tag, "_count"}, 32'(bus.out_count), exp_cnt);
        $display("txn %0d %s: sum=%08h count=%0d (expected %08h/%0d)",
                 n_txn, tag, bus.out_sum, bus.out_count, exp_sum, exp_cnt);
        n_txn++;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_seq(input string tag, input logic [31:0] terms[$]);
        foreach (terms[i]) send_term(terms[i], (i == terms.size() - 1));
        get_result(tag, ref_dot(terms), ref_cnt(terms.size()));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_sum"},   bus.out_sum,        32'd0);
        check({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        logic [31:0] q[$];
        logic [31:0] held;
        int n;

        n_checks = 0;
        n_errors = 0;
        n_txn    = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("post_reset");

        // 1.5 + 2.25 with output latency measured from the accepting edge
        send_term(32'h3FC00000, 1'b0);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_latency", 32'(n), 32'd3);
        send_term(32'h40100000, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_latency", 32'(n), 32'd3);
        get_result("add_1p5_2p25", 32'h40700000, 32'd2);

        q = '{32'h40400000, 32'hC0400000};
        run_seq("cancel", q);
        check("cancel_model", ref_dot(q), 32'h00000000);

        q = '{32'h3F800000, 32'h7FC00001, 32'h3F800000};
        run_seq("nan_sticky", q);

        q = '{32'h7F800000, 32'hFF800000};
        run_seq("inf_minus_inf", q);

        q = '{32'h7F7FFFFF, 32'h7F7FFFFF};
        run_seq("overflow", q);

        q = '{32'hFF800000, 32'h3F800000};
        run_seq("neg_inf", q);

        // Output held while the consumer stalls; input must not be taken
        send_term(32'h3F800000, 1'b0);
        send_term(32'h40000000, 1'b1);
        wait_out_valid();
        held = bus.out_sum;
        check("hold_value", held, 32'h40400000);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h41200000;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_sum",      bus.out_sum,        held);
            check("hold_in_ready", 32'(bus.in_ready),  32'd0);
            check("hold_valid",    32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        get_result("held", 32'h40400000, 32'd2);
        q = '{32'hC0A00000};
        run_seq("after_hold", q);

        // Reset during ADD of the third term
        send_term(32'h3F800000, 1'b0);
        send_term(32'h40000000, 1'b0);
        send_term(32'h40400000, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        q = '{32'h3F800000};
        run_seq("after_reset", q);

        // Counter saturation
        q = {};
        for (int i = 0; i < 18; i++) q.push_back(32'h3F800000 + 32'(i));
        run_seq("count_sat", q);

        // Randomised dot products
        for (int t = 0; t < 30; t++) begin
            int len;
            len = $urandom_range(1, 6);
            q = {};
            for (int i = 0; i < len; i++) q.push_back(rand_term());
            run_seq("random", q);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends on its own
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
